// File: rtl/toy_uart_pkg.sv
// Shared definitions for the toy UART receiver and transmitter.
package toy_uart_pkg;

    localparam int DATA_BITS        = 8;
    localparam int BAUD_DIV_DEFAULT = 2604;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_STOP
    } rx_state_t;

endpackage

// File: rtl/toy_sync_fifo.sv
// Single-clock first-word-fall-through FIFO.
module toy_sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             push,
    input  logic [WIDTH-1:0] wdata,
    input  logic             pop,
    output logic [WIDTH-1:0] rdata,
    output logic             full,
    output logic             empty,
    output logic [$clog2(DEPTH):0] count
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW-1:0] PSTEP = AW'(1);
    localparam logic [AW:0]   CSTEP = (AW+1)'(1);
    localparam logic [AW:0]   CFULL = (AW+1)'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             do_pop;
    logic             do_push;

    assign full    = (count == CFULL);
    assign empty   = (count == '0);
    assign do_pop  = pop & ~empty;
    // A pop frees the slot this cycle, so a full FIFO still takes the push.
    assign do_push = push & (~full | do_pop);
    assign rdata   = empty ? '0 : mem[rd_ptr];

    always_ff @(posedge i_clk) begin
        if (do_push) begin
            mem[wr_ptr] <= wdata;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + PSTEP;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + PSTEP;
            end
            unique case ({do_push, do_pop})
                2'b10:   count <= count + CSTEP;
                2'b01:   count <= count - CSTEP;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/toy_uart_rx.sv
// 8N1 UART receiver with a small FWFT byte FIFO and error pulses.
module toy_uart_rx
    import toy_uart_pkg::*;
#(
    parameter int BAUD_DIV   = BAUD_DIV_DEFAULT,
    parameter int FIFO_DEPTH = 4
) (
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic       i_rx,
    output logic [7:0] o_data,
    output logic       o_valid,
    input  logic       i_ready,
    output logic       o_frame_err,
    output logic       o_overrun
);

    localparam int CW = $clog2(BAUD_DIV);
    localparam int BW = $clog2(DATA_BITS);
    localparam int FW = $clog2(FIFO_DEPTH);
    localparam logic [CW-1:0] HALF   = CW'(BAUD_DIV / 2 - 1);
    localparam logic [CW-1:0] RELOAD = CW'(BAUD_DIV - 1);
    localparam logic [CW-1:0] CSTEP  = CW'(1);
    localparam logic [BW-1:0] BSTEP  = BW'(1);
    localparam logic [BW-1:0] LAST   = BW'(DATA_BITS - 1);

    rx_state_t            state;
    logic                 sync1;
    logic                 sync;
    logic                 prev;
    logic [CW-1:0]        cnt;
    logic [BW-1:0]        bit_idx;
    logic [DATA_BITS-1:0] shift;
    logic                 tick;
    logic                 fall;
    logic                 push_req;
    logic                 fifo_full;
    logic                 fifo_empty;
    logic [FW:0]          fifo_count;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            sync1 <= 1'b1;
            sync  <= 1'b1;
            prev  <= 1'b1;
        end else begin
            sync1 <= i_rx;
            sync  <= sync1;
            prev  <= sync;
        end
    end

    assign fall     = prev & ~sync;
    assign tick     = (cnt == '0);
    assign push_req = ~i_rst & (state == ST_STOP) & tick & sync;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state       <= ST_IDLE;
            cnt         <= '0;
            bit_idx     <= '0;
            shift       <= '0;
            o_frame_err <= 1'b0;
        end else begin
            o_frame_err <= 1'b0;
            if (state != ST_IDLE) begin
                cnt <= tick ? RELOAD : cnt - CSTEP;
            end
            unique case (state)
                ST_IDLE: begin
                    // First sample lands mid-start-bit.
                    if (fall) begin
                        cnt   <= HALF;
                        state <= ST_START;
                    end
                end
                ST_START: begin
                    if (tick) begin
                        bit_idx <= '0;
                        state   <= sync ? ST_IDLE : ST_DATA;
                    end
                end
                ST_DATA: begin
                    if (tick) begin
                        shift   <= {sync, shift[DATA_BITS-1:1]};
                        bit_idx <= bit_idx + BSTEP;
                        if (bit_idx == LAST) begin
                            state <= ST_STOP;
                        end
                    end
                end
                ST_STOP: begin
                    if (tick) begin
                        o_frame_err <= ~sync;
                        state       <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    assign o_valid   = ~fifo_empty;
    assign o_overrun = push_req & fifo_full & ~i_ready;

    toy_sync_fifo #(
        .WIDTH (8),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .i_clk (i_clk),
        .i_rst (i_rst),
        .push  (push_req),
        .wdata (shift),
        .pop   (i_ready),
        .rdata (o_data),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifo_count)
    );

endmodule

// File: tb/tb_toy_uart_rx.sv
// Directed bench for toy_uart_rx at BAUD_DIV=16, FIFO_DEPTH=4.
module tb_toy_uart_rx;

    localparam int BD  = 16;
    localparam int FD  = 4;
    localparam int LAT = 155;

    logic       clk = 1'b0;
    logic       rst;
    logic       rx;
    logic       ready;
    logic [7:0] data;
    logic       valid;
    logic       ferr;
    logic       ovr;

    int n_cmp = 0;
    int n_bad = 0;
    int err_cnt = 0;
    int ovr_cnt = 0;

    always #5 clk = ~clk;

    toy_uart_rx #(
        .BAUD_DIV   (BD),
        .FIFO_DEPTH (FD)
    ) dut (
        .i_clk       (clk),
        .i_rst       (rst),
        .i_rx        (rx),
        .o_data      (data),
        .o_valid     (valid),
        .i_ready     (ready),
        .o_frame_err (ferr),
        .o_overrun   (ovr)
    );

    always @(negedge clk) begin
        if (ferr) err_cnt <= err_cnt + 1;
        if (ovr)  ovr_cnt <= ovr_cnt + 1;
    end

    typedef struct {
        logic [7:0] d;
        logic       stopb;
        logic       exp_v;
        int         exp_err;
    } vec_t;

    vec_t tbl [6];

    task automatic check(input string nm, input int act, input int exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Drives one frame; pop_cyc raises i_ready for that single cycle.
    task automatic send(input logic [7:0] b, input logic stopb,
                        input int pop_cyc, output int first_v);
        first_v = -1;
        for (int c = 0; c < 10 * BD; c++) begin
            int k;
            k = c / BD;
            if (k == 0)      rx = 1'b0;
            else if (k <= 8) rx = b[k-1];
            else             rx = stopb;
            ready = (c == pop_cyc);
            @(negedge clk);
            if (valid && first_v < 0) first_v = c;
            @(posedge clk);
            #1;
        end
        ready = 1'b0;
    endtask

    task automatic pop_expect(input logic [7:0] e, input string nm);
        @(negedge clk);
        check({nm, " valid"}, int'(valid), 1);
        check({nm, " data"}, int'(data), int'(e));
        @(posedge clk);
        #1;
        ready = 1'b1;
        @(posedge clk);
        #1;
        ready = 1'b0;
    endtask

    task automatic expect_empty(input string nm);
        @(negedge clk);
        check({nm, " empty"}, int'(valid), 0);
        @(posedge clk);
        #1;
    endtask

    initial begin
        int fv;
        int e0;
        int o0;

        tbl[0] = '{8'hA5, 1'b1, 1'b1, 0};
        tbl[1] = '{8'h3C, 1'b1, 1'b1, 0};
        tbl[2] = '{8'h00, 1'b1, 1'b1, 0};
        tbl[3] = '{8'hFF, 1'b1, 1'b1, 0};
        tbl[4] = '{8'h55, 1'b0, 1'b0, 1};
        tbl[5] = '{8'hC3, 1'b1, 1'b1, 0};

        rst   = 1'b1;
        rx    = 1'b1;
        ready = 1'b0;
        idle(3);
        @(negedge clk);
        check("reset valid", int'(valid), 0);
        check("reset data", int'(data), 0);
        check("reset ferr", int'(ferr), 0);
        check("reset ovr", int'(ovr), 0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        idle(4);

        for (int i = 0; i < 6; i++) begin
            e0 = err_cnt;
            o0 = ovr_cnt;
            send(tbl[i].d, tbl[i].stopb, -1, fv);
            rx = 1'b1;
            idle(4);
            check($sformatf("vec%0d latency", i), fv,
                  tbl[i].exp_v ? LAT : -1);
            check($sformatf("vec%0d ferr", i), err_cnt - e0, tbl[i].exp_err);
            check($sformatf("vec%0d ovr", i), ovr_cnt - o0, 0);
            if (tbl[i].exp_v) begin
                pop_expect(tbl[i].d, $sformatf("vec%0d", i));
            end
            expect_empty($sformatf("vec%0d", i));
        end

        // Short low glitch must not start a frame.
        e0 = err_cnt;
        rx = 1'b0;
        idle(4);
        rx = 1'b1;
        idle(24);
        check("glitch ferr", err_cnt - e0, 0);
        expect_empty("glitch");
        send(8'h3C, 1'b1, -1, fv);
        rx = 1'b1;
        idle(4);
        check("glitch next latency", fv, LAT);
        pop_expect(8'h3C, "glitch next");

        // Low stop bit followed by a long break.
        e0 = err_cnt;
        send(8'h55, 1'b0, -1, fv);
        idle(40 * BD);
        rx = 1'b1;
        idle(8);
        check("break ferr", err_cnt - e0, 1);
        expect_empty("break");

        o0 = ovr_cnt;
        e0 = err_cnt;
        for (int i = 1; i <= 5; i++) begin
            send(8'(i), 1'b1, -1, fv);
        end
        rx = 1'b1;
        idle(4);
        check("overrun ovr", ovr_cnt - o0, 1);
        check("overrun ferr", err_cnt - e0, 0);
        for (int i = 1; i <= 4; i++) begin
            pop_expect(8'(i), $sformatf("overrun pop%0d", i));
        end
        expect_empty("overrun");

        // Full FIFO with a pop on the stop-sample cycle.
        o0 = ovr_cnt;
        for (int i = 1; i <= 4; i++) begin
            send(8'(i), 1'b1, -1, fv);
        end
        send(8'h99, 1'b1, LAT - 1, fv);
        rx = 1'b1;
        idle(4);
        check("fullpop ovr", ovr_cnt - o0, 0);
        pop_expect(8'h02, "fullpop a");
        pop_expect(8'h03, "fullpop b");
        pop_expect(8'h04, "fullpop c");
        pop_expect(8'h99, "fullpop d");
        expect_empty("fullpop");

        // Reset in the middle of data bit 3 of 0xFF.
        send(8'h11, 1'b1, -1, fv);
        e0 = err_cnt;
        o0 = ovr_cnt;
        rx = 1'b0;
        idle(BD);
        rx = 1'b1;
        idle(3 * BD + BD / 2);
        rst = 1'b1;
        idle(1);
        rst = 1'b0;
        @(negedge clk);
        check("midrst valid", int'(valid), 0);
        check("midrst data", int'(data), 0);
        check("midrst ferr", int'(ferr), 0);
        check("midrst ovr", int'(ovr), 0);
        @(posedge clk);
        #1;
        idle(6 * BD);
        check("midrst ferr cnt", err_cnt - e0, 0);
        check("midrst ovr cnt", ovr_cnt - o0, 0);
        expect_empty("midrst");
        send(8'h7E, 1'b1, -1, fv);
        rx = 1'b1;
        idle(4);
        check("midrst next latency", fv, LAT);
        pop_expect(8'h7E, "midrst next");
        expect_empty("midrst next");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
